// File: rtl/ram_1w_nrs_pipe_pkg.sv
// Shared definitions for ram_1w_nrs_pipe: parameter bounds, address-width
// helper and the lane-merge used by both the write path and the read bypass.
package ram_1w_nrs_pipe_pkg;

  localparam int WORD_COUNT_MIN = 2;
  localparam int WORD_COUNT_MAX = 65536;
  localparam int READ_PORTS_MIN = 1;
  localparam int READ_PORTS_MAX = 4;
  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 3;

  // Widest word the merge helper handles; callers widen/narrow with casts.
  localparam int MAX_WORD_W = 1024;
  localparam int MAX_IDX_W  = $clog2(MAX_WORD_W);

  typedef logic [MAX_WORD_W-1:0] wide_word_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Lane i of the result comes from new_word when mask[i] is set, else old_word.
  function automatic wide_word_t lane_merge(input wide_word_t old_word,
                                            input wide_word_t new_word,
                                            input wide_word_t mask,
                                            input int         lane_w);
    wide_word_t           merged;
    logic [MAX_IDX_W-1:0] bit_idx;
    logic [MAX_IDX_W-1:0] lane_idx;
    merged = old_word;
    for (int b = 0; b < MAX_WORD_W; b++) begin
      bit_idx  = MAX_IDX_W'(b);
      lane_idx = MAX_IDX_W'(b / lane_w);
      if (mask[lane_idx]) merged[bit_idx] = new_word[bit_idx];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_1w_nrs_pipe_rdport.sv
// One synchronous read port: array sample (with write-first merge when
// RAM_1W_NRS_PIPE_BYPASS_EN is defined), RD_LATENCY-1 register stages, valid.
module ram_1w_nrs_pipe_rdport
  import ram_1w_nrs_pipe_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rd_en,
  input  logic [WORD_WIDTH-1:0] rd_word,
`ifdef RAM_1W_NRS_PIPE_BYPASS_EN
  input  logic                  byp_hit,
  input  logic [WORD_WIDTH-1:0] byp_data,
  input  logic [MASK_WIDTH-1:0] byp_mask,
`endif
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int LANE_W = WORD_WIDTH / MASK_WIDTH;

  logic [WORD_WIDTH-1:0] sample_word;
  logic [WORD_WIDTH-1:0] data_p [RD_LATENCY];
  logic [RD_LATENCY-1:0] vld_p;

`ifdef RAM_1W_NRS_PIPE_BYPASS_EN
  assign sample_word = byp_hit
    ? WORD_WIDTH'(lane_merge(wide_word_t'(rd_word), wide_word_t'(byp_data),
                             wide_word_t'(byp_mask), LANE_W))
    : rd_word;
`else
  assign sample_word = rd_word;
`endif

  // Stage p0 samples the array; stages p1.. only copy forward when a valid
  // read moves into them, so every stage holds its word between reads.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_en;
      for (int k = 1; k < RD_LATENCY; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) data_p[0] <= sample_word;
    for (int k = 1; k < RD_LATENCY; k++) begin
      if (vld_p[k-1]) data_p[k] <= data_p[k-1];
    end
    if (!resetn) data_p[RD_LATENCY-1] <= '0;
  end

  assign rd_data  = data_p[RD_LATENCY-1];
  assign rd_valid = vld_p[RD_LATENCY-1];

endmodule

// File: rtl/ram_1w_nrs_pipe.sv
// Single-write, multi-read masked RAM with pipelined synchronous reads.
// Define RAM_1W_NRS_PIPE_BYPASS_EN for write-first same-address reads.
module ram_1w_nrs_pipe
  import ram_1w_nrs_pipe_pkg::*;
#(
  parameter int WORD_COUNT = 512,
  parameter int WORD_WIDTH = 32,
  parameter int MASK_WIDTH = 4,
  parameter int READ_PORTS = 2,
  parameter int RD_LATENCY = 1,
  localparam int AW = clog2(WORD_COUNT)
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             wr_en,
  input  logic [MASK_WIDTH-1:0]            wr_mask,
  input  logic [AW-1:0]                    wr_addr,
  input  logic [WORD_WIDTH-1:0]            wr_data,
  input  logic [READ_PORTS-1:0]            rd_en,
  input  logic [READ_PORTS*AW-1:0]         rd_addr,
  output logic [READ_PORTS*WORD_WIDTH-1:0] rd_data,
  output logic [READ_PORTS-1:0]            rd_valid
);

  if (WORD_COUNT < WORD_COUNT_MIN || WORD_COUNT > WORD_COUNT_MAX) begin : g_bad_word_count
    $error("ram_1w_nrs_pipe: WORD_COUNT out of range");
  end
  if (READ_PORTS < READ_PORTS_MIN || READ_PORTS > READ_PORTS_MAX) begin : g_bad_read_ports
    $error("ram_1w_nrs_pipe: READ_PORTS out of range");
  end
  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_rd_latency
    $error("ram_1w_nrs_pipe: RD_LATENCY out of range");
  end
  if (MASK_WIDTH < 1 || WORD_WIDTH < 1 || (WORD_WIDTH % MASK_WIDTH) != 0) begin : g_bad_mask
    $error("ram_1w_nrs_pipe: WORD_WIDTH must be a multiple of MASK_WIDTH");
  end
  if (WORD_WIDTH > MAX_WORD_W) begin : g_bad_word_width
    $error("ram_1w_nrs_pipe: WORD_WIDTH exceeds supported maximum");
  end

  localparam int          LANE_W = WORD_WIDTH / MASK_WIDTH;
  // One extra bit so WORD_COUNT itself is representable for the range compare.
  localparam logic [AW:0] WC_LIM = (AW+1)'(WORD_COUNT);

  logic [WORD_WIDTH-1:0] mem [WORD_COUNT];
  logic                  wr_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < WC_LIM);

  // Array contents are never reset; writes are simply held off during reset.
  always_ff @(posedge clk) begin
    if (resetn && wr_en && wr_in_range)
      mem[wr_addr] <= WORD_WIDTH'(lane_merge(wide_word_t'(mem[wr_addr]), wide_word_t'(wr_data),
                                             wide_word_t'(wr_mask), LANE_W));
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
    logic [AW-1:0]         addr;
    logic                  in_range;
    logic [WORD_WIDTH-1:0] word;

    assign addr     = rd_addr[p*AW +: AW];
    assign in_range = ({1'b0, addr} < WC_LIM);
    assign word     = in_range ? mem[addr] : '0;

`ifdef RAM_1W_NRS_PIPE_BYPASS_EN
    logic hit;
    assign hit = wr_en && wr_in_range && (addr == wr_addr);
`endif

    ram_1w_nrs_pipe_rdport #(
      .WORD_WIDTH (WORD_WIDTH),
      .MASK_WIDTH (MASK_WIDTH),
      .RD_LATENCY (RD_LATENCY)
    ) u_rdport (
      .clk      (clk),
      .resetn   (resetn),
      .rd_en    (rd_en[p]),
      .rd_word  (word),
`ifdef RAM_1W_NRS_PIPE_BYPASS_EN
      .byp_hit  (hit),
      .byp_data (wr_data),
      .byp_mask (wr_mask),
`endif
      .rd_data  (rd_data[p*WORD_WIDTH +: WORD_WIDTH]),
      .rd_valid (rd_valid[p])
    );
  end

endmodule

// File: tb/tb_ram_1w_nrs_pipe.sv
// Bench for ram_1w_nrs_pipe: three instances (RD_LATENCY 1..3) share stimulus
// and are compared every cycle against a scheduled-read reference model.
module tb_ram_1w_nrs_pipe;

  localparam int WC = 300;
  localparam int WW = 32;
  localparam int MW = 4;
  localparam int LW = WW / MW;
  localparam int RP = 2;
  localparam int AW = 9;

  logic             clk = 1'b0;
  logic             resetn;
  logic             wr_en;
  logic [MW-1:0]    wr_mask;
  logic [AW-1:0]    wr_addr;
  logic [WW-1:0]    wr_data;
  logic [RP-1:0]    rd_en;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*WW-1:0] rd_data_l  [1:3];
  logic [RP-1:0]    rd_valid_l [1:3];

  always #5 clk = ~clk;

  for (genvar L = 1; L <= 3; L++) begin : g_dut
    ram_1w_nrs_pipe #(
      .WORD_COUNT (WC),
      .WORD_WIDTH (WW),
      .MASK_WIDTH (MW),
      .READ_PORTS (RP),
      .RD_LATENCY (L)
    ) u_dut (
      .clk      (clk),
      .resetn   (resetn),
      .wr_en    (wr_en),
      .wr_mask  (wr_mask),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data_l[L]),
      .rd_valid (rd_valid_l[L])
    );
  end

  // Reference model: memory image plus a list of reads scheduled to appear.
  typedef struct {
    int            due;
    int            lat;
    int            port;
    logic [WW-1:0] data;
  } rd_evt_t;

  logic [WW-1:0] ref_mem [WC];
  rd_evt_t       pend [$];
  logic [WW-1:0] exp_d [1:3][RP];
  logic          exp_v [1:3][RP];
  int            cyc;
  int            n_vec;
  int            n_bad;

  function automatic logic [WW-1:0] apply_mask(input logic [WW-1:0] old_w,
                                               input logic [WW-1:0] new_w,
                                               input logic [MW-1:0] m);
    logic [WW-1:0] r;
    r = old_w;
    for (int i = 0; i < MW; i++) if (m[i]) r[i*LW +: LW] = new_w[i*LW +: LW];
    return r;
  endfunction

  task automatic model_edge();
    int            a;
    logic [WW-1:0] w;
    cyc++;
    if (!resetn) begin
      pend.delete();
      for (int L = 1; L <= 3; L++)
        for (int p = 0; p < RP; p++) begin
          exp_v[L][p] = 1'b0;
          exp_d[L][p] = '0;
        end
    end else begin
      for (int p = 0; p < RP; p++) begin
        if (rd_en[p]) begin
          a = int'(rd_addr[p*AW +: AW]);
          w = (a < WC) ? ref_mem[a] : '0;
`ifdef RAM_1W_NRS_PIPE_BYPASS_EN
          if (wr_en && int'(wr_addr) == a && a < WC) w = apply_mask(w, wr_data, wr_mask);
`endif
          for (int L = 1; L <= 3; L++) pend.push_back('{cyc + L - 1, L, p, w});
        end
      end
      if (wr_en && int'(wr_addr) < WC)
        ref_mem[wr_addr] = apply_mask(ref_mem[wr_addr], wr_data, wr_mask);
      for (int L = 1; L <= 3; L++)
        for (int p = 0; p < RP; p++) exp_v[L][p] = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].due == cyc) begin
          exp_v[pend[i].lat][pend[i].port] = 1'b1;
          exp_d[pend[i].lat][pend[i].port] = pend[i].data;
          pend.delete(i);
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [WW:0] act, input logic [WW:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got v=%0b d=%h, want v=%0b d=%h",
               name, cyc, act[WW], act[WW-1:0], req[WW], req[WW-1:0]);
    end
  endtask

  task automatic check_model();
    for (int L = 1; L <= 3; L++)
      for (int p = 0; p < RP; p++)
        chk($sformatf("model_lat%0d_p%0d", L, p),
            {rd_valid_l[L][p], rd_data_l[L][p*WW +: WW]}, {exp_v[L][p], exp_d[L][p]});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_idle();
    wr_en   = 1'b0;
    wr_mask = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = '0;
    rd_addr = '0;
  endtask

  typedef struct {
    logic          we;
    logic [MW-1:0] wm;
    logic [AW-1:0] wa;
    logic [WW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          ev;
    logic [WW-1:0] erf;
    logic [WW-1:0] ewf;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [WW-1:0] e;
    cyc   = 0;
    n_vec = 0;
    n_bad = 0;
    resetn = 1'b0;
    set_idle();

    // Table: L=1 port 0 expectations, read-first / write-first.
    tbl[0]  = '{1'b1, 4'hF, 9'd7,   32'h11223344, 1'b0, 9'd0,   1'b0, 32'h0,        32'h0};
    tbl[1]  = '{1'b1, 4'h5, 9'd7,   32'hAABBCCDD, 1'b1, 9'd7,   1'b1, 32'h11223344, 32'h11BB33DD};
    tbl[2]  = '{1'b0, 4'h0, 9'd0,   32'h0,        1'b1, 9'd7,   1'b1, 32'h11BB33DD, 32'h11BB33DD};
    tbl[3]  = '{1'b1, 4'hF, 9'd310, 32'hFFFFFFFF, 1'b1, 9'd310, 1'b1, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 4'hF, 9'd299, 32'h12345678, 1'b0, 9'd0,   1'b0, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, 4'hF, 9'd310, 32'h99999999, 1'b1, 9'd299, 1'b1, 32'h12345678, 32'h12345678};
    tbl[6]  = '{1'b0, 4'h0, 9'd0,   32'h0,        1'b1, 9'd310, 1'b1, 32'h0,        32'h0};
    tbl[7]  = '{1'b1, 4'hF, 9'd5,   32'hDEADBEEF, 1'b0, 9'd0,   1'b0, 32'h0,        32'h0};
    tbl[8]  = '{1'b0, 4'h0, 9'd0,   32'h0,        1'b1, 9'd5,   1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[9]  = '{1'b0, 4'h0, 9'd0,   32'h0,        1'b0, 9'd0,   1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[10] = '{1'b1, 4'h0, 9'd5,   32'h0,        1'b1, 9'd5,   1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[11] = '{1'b1, 4'h3, 9'd5,   32'h0000CAFE, 1'b1, 9'd5,   1'b1, 32'hDEADBEEF, 32'hDEADCAFE};
    tbl[12] = '{1'b0, 4'h0, 9'd0,   32'h0,        1'b1, 9'd5,   1'b1, 32'hDEADCAFE, 32'hDEADCAFE};

    repeat (3) step();
    for (int L = 1; L <= 3; L++)
      chk($sformatf("reset_lat%0d", L), {1'b0, 30'd0, rd_valid_l[L], rd_data_l[L][WW-1:0]}, '0);
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      set_idle();
      wr_en   = tbl[i].we;
      wr_mask = tbl[i].wm;
      wr_addr = tbl[i].wa;
      wr_data = tbl[i].wd;
      rd_en   = {1'b0, tbl[i].re};
      rd_addr[AW-1:0] = tbl[i].ra;
      step();
`ifdef RAM_1W_NRS_PIPE_BYPASS_EN
      e = tbl[i].ewf;
`else
      e = tbl[i].erf;
`endif
      chk($sformatf("tbl%0d", i), {rd_valid_l[1][0], rd_data_l[1][WW-1:0]}, {tbl[i].ev, e});
    end
    set_idle();
    repeat (3) step();

    // Fill every in-range word so later random reads see known contents.
    for (int a = 0; a < WC; a++) begin
      wr_en   = 1'b1;
      wr_mask = 4'hF;
      wr_addr = AW'(a);
      wr_data = $urandom;
      step();
    end
    set_idle();

    // Latency-2 read of a freshly written word.
    wr_en = 1'b1; wr_mask = 4'hF; wr_addr = 9'd5; wr_data = 32'hDEADBEEF;
    step();
    set_idle();
    rd_en = 2'b01; rd_addr[AW-1:0] = 9'd5;
    step();
    chk("lat2_edge0", {rd_valid_l[2][0], rd_data_l[2][WW-1:0]}, {1'b0, rd_data_l[2][WW-1:0]});
    set_idle();
    step();
    chk("lat2_edge1", {rd_valid_l[2][0], rd_data_l[2][WW-1:0]}, {1'b1, 32'hDEADBEEF});
    step();
    chk("lat2_hold", {rd_valid_l[2][0], rd_data_l[2][WW-1:0]}, {1'b0, 32'hDEADBEEF});

    // Both ports streaming the same address.
    wr_en = 1'b1; wr_mask = 4'hF; wr_addr = 9'd3; wr_data = 32'h0000CAFE;
    step();
    set_idle();
    rd_en = 2'b11; rd_addr = {9'd3, 9'd3};
    for (int i = 0; i < 8; i++) begin
      step();
      for (int p = 0; p < RP; p++)
        chk($sformatf("stream%0d_p%0d", i, p),
            {rd_valid_l[1][p], rd_data_l[1][p*WW +: WW]}, {1'b1, 32'h0000CAFE});
    end
    set_idle();
    repeat (4) step();

    // Reset with latency-3 reads in flight.
    rd_en = 2'b11; rd_addr = {9'd5, 9'd5};
    step();
    step();
    set_idle();
    resetn = 1'b0;
    step();
    chk("rst_flush_v", {{(WW-1){1'b0}}, rd_valid_l[3]}, '0);
    chk("rst_flush_d", {1'b0, rd_data_l[3][WW +: WW] | rd_data_l[3][WW-1:0]}, '0);
    resetn = 1'b1;
    step();
    chk("rst_drop0", {rd_valid_l[3][0], rd_data_l[3][WW-1:0]}, '0);
    step();
    chk("rst_drop1", {rd_valid_l[3][1], rd_data_l[3][2*WW-1:WW]}, '0);
    rd_en = 2'b01; rd_addr[AW-1:0] = 9'd5;
    step();
    chk("post_rst_e0", {rd_valid_l[3][0], rd_data_l[3][WW-1:0]}, '0);
    set_idle();
    step();
    chk("post_rst_e1", {rd_valid_l[3][0], rd_data_l[3][WW-1:0]}, '0);
    step();
    chk("post_rst_e2", {rd_valid_l[3][0], rd_data_l[3][WW-1:0]}, {1'b1, 32'hDEADBEEF});

    // Random traffic with frequent address collisions and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      resetn  = ($urandom_range(0, 149) != 0);
      wr_en   = $urandom_range(0, 1) == 1;
      wr_mask = MW'($urandom);
      wr_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 319));
      wr_data = $urandom;
      rd_en   = RP'($urandom);
      for (int p = 0; p < RP; p++)
        rd_addr[p*AW +: AW] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15))
                                                          : AW'($urandom_range(0, 319));
      step();
    end
    resetn = 1'b1;
    set_idle();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_1w_nrs_pipe.md
RAM_1W_NRS_PIPE -- requirements
Module: ram_1w_nrs_pipe

Interface
REQ-001 The block SHALL have parameter WORD_COUNT, default 512, meaning the number of words, 2..65536, not required to be a power of two.
REQ-002 The block SHALL have parameter WORD_WIDTH, default 32, meaning the bits per word.
REQ-003 The block SHALL have parameter MASK_WIDTH, default 4, meaning the write-mask lanes; WORD_WIDTH SHALL be a multiple of MASK_WIDTH.
REQ-004 The block SHALL have parameter READ_PORTS, default 2, meaning the number of independent synchronous read ports, 1..4.
REQ-005 The block SHALL have parameter RD_LATENCY, default 1, meaning the cycles from rd_en to rd_data, 1..3.
REQ-006 The block SHALL use AW = clog2(WORD_COUNT) as the address width.
REQ-007 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-008 Port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-009 Port wr_en, input, 1 bit: write request.
REQ-010 Port wr_mask, input, MASK_WIDTH bits: per-lane write enable.
REQ-011 Port wr_addr, input, AW bits: write address.
REQ-012 Port wr_data, input, WORD_WIDTH bits: write data.
REQ-013 Port rd_en, input, READ_PORTS bits: per-port read request.
REQ-014 Port rd_addr, input, READ_PORTS*AW bits: port p uses slice [p*AW +: AW].
REQ-015 Port rd_data, output, READ_PORTS*WORD_WIDTH bits: port p uses slice [p*WORD_WIDTH +: WORD_WIDTH].
REQ-016 Port rd_valid, output, READ_PORTS bits: port p's rd_data is new this cycle.

Function
REQ-017 A write with wr_en=1 SHALL update only the lanes whose wr_mask bit is 1, each lane being WORD_WIDTH/MASK_WIDTH bits, at the clk edge.
REQ-018 A write with wr_addr >= WORD_COUNT SHALL be discarded.
REQ-019 A read sampled with rd_en[p]=1 at edge N SHALL present its data on rd_data[p] with rd_valid[p]=1 after edge N+RD_LATENCY-1.
REQ-020 A read at rd_addr >= WORD_COUNT SHALL return all-zero data, with rd_valid still asserted.
REQ-021 The read pipeline SHALL accept a new read on every port every cycle, with no stalls and no back-pressure.
REQ-022 When no valid read reaches the output stage of port p, rd_valid[p] SHALL be 0 and rd_data[p] SHALL hold its last value.
REQ-023 Ports SHALL be independent: any number of ports MAY read the same address in the same cycle and each SHALL return identical data.
REQ-024 For RD_LATENCY>1, the extra stages SHALL be registers only; data SHALL NOT be re-sampled from the array after the first stage.
REQ-025 Read-under-write at the same address in the same cycle SHALL follow REQ-031/REQ-032.

Reset
REQ-026 While resetn=0 at a clk edge, all rd_valid SHALL be 0 after that edge.
REQ-027 While resetn=0 at a clk edge, all rd_data SHALL be zero after that edge.
REQ-028 While resetn=0, all pipeline valid bits SHALL clear.
REQ-029 While resetn=0, writes SHALL be blocked.
REQ-030 Reset SHALL NOT initialise array contents, and reads in flight when reset is asserted SHALL be dropped and never produce rd_valid.

Configuration
REQ-031 With macro RAM_1W_NRS_PIPE_BYPASS_EN defined, a read at the same address as a same-cycle write SHALL return the new data in masked lanes and the old data in unmasked lanes (write-first).
REQ-032 Without RAM_1W_NRS_PIPE_BYPASS_EN, that read SHALL return the pre-write word (read-first), and no address-compare logic SHALL be built.

Structure
REQ-033 Package ram_1w_nrs_pipe_pkg SHALL hold the clog2 function, the RD_LATENCY and READ_PORTS bounds, and the lane-merge function shared by the write path and the bypass path.
REQ-034 Sub-module ram_1w_nrs_pipe_rdport SHALL implement one read port (first-stage sample, optional bypass merge, RD_LATENCY-1 delay stages, valid tracking) and SHALL be instantiated READ_PORTS times.
REQ-035 Parameter violations SHALL be caught by elaboration-time checks.

Verification
REQ-036 Write 0xDEADBEEF to address 5 with mask 0xF, then read address 5 on port 0 with RD_LATENCY=2 -> rd_valid[0] high exactly 2 edges after the read request, rd_data 0xDEADBEEF, rd_valid low the next cycle with data held.
REQ-037 Address 7 holds 0x11223344; in the same cycle write 0xAABBCCDD to address 7 with mask 0x5 and read address 7 -> 0x11BB33DD with bypass defined, 0x11223344 without.
REQ-038 Ports 0 and 1 read address 3 (holding 0x0000CAFE) on back-to-back cycles for 8 cycles -> both ports return 0x0000CAFE every cycle with rd_valid continuously high.
REQ-039 With WORD_COUNT=300, write address 310 then read addresses 310 and 299 -> address 310 reads 0x0, and address 299 is unchanged.
REQ-040 Issue reads on cycles 0 and 1 with RD_LATENCY=3 and drive resetn low on cycle 2 -> no rd_valid pulse appears, rd_data is 0 after reset, and the first read issued after reset returns correct data at latency 3.
